// File: rtl/rotate_sequencer_if.sv
// Command handshake bundle for the ring-rotator sequencer.
interface rotate_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_pattern;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;

  modport master (
    output cmd_valid,
    output cmd_pattern,
    output cmd_dir,
    output cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_pattern,
    input  cmd_dir,
    input  cmd_steps,
    output cmd_ready
  );
endinterface

// File: rtl/rotate_sequencer.sv
// Command-driven ring rotator: loads a pattern and rotates it
// one position every DIV clocks for a commanded number of steps.
module rotate_sequencer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  rotate_sequencer_if.slave cmd,
  input  logic             abort,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             step,
  output logic             done
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] remaining_q;
  logic             dir_q;
  logic             accept;
  logic             tick;
  logic             wrap;
  logic [WIDTH-1:0] rot;

  assign wrap = (presc_q == PW'(DIV - 1));

  always_comb begin
    rot = dir_q ? {out[0], out[WIDTH-1:1]}
                : {out[WIDTH-2:0], out[WIDTH-1]};
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    tick    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid && cmd.cmd_ready) begin
          accept  = 1'b1;
          state_d = (cmd.cmd_steps == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        // abort wins over a coincident tick
        if (abort) begin
          state_d = FIN;
        end else if (wrap) begin
          tick = 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      out           <= {{(WIDTH-1){1'b0}}, 1'b1};
      cmd.cmd_ready <= 1'b1;
      busy          <= 1'b0;
      step          <= 1'b0;
      done          <= 1'b0;
      presc_q       <= '0;
      remaining_q   <= '0;
      dir_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd.cmd_ready <= (state_d == IDLE);
      busy          <= (state_d == RUN);
      done          <= (state_d == FIN);
      step          <= tick;
      if (accept) begin
        out         <= cmd.cmd_pattern;
        dir_q       <= cmd.cmd_dir;
        remaining_q <= cmd.cmd_steps;
        presc_q     <= '0;
      end else if (state_q == RUN && !abort) begin
        presc_q <= wrap ? '0 : presc_q + PW'(1);
        if (tick) begin
          out         <= rot;
          remaining_q <= remaining_q - CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer: command table plus
// reset corner cases.
module tb_rotate_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       abort;
  logic [3:0] out;
  logic       busy;
  logic       step;
  logic       done;

  int errors = 0;
  int checks = 0;

  rotate_sequencer_if #(.WIDTH(4), .CNT_W(8)) cif ();

  rotate_sequencer #(.WIDTH(4), .DIV(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cif),
    .abort (abort),
    .out   (out),
    .busy  (busy),
    .step  (step),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pattern;
    logic       dir;
    int         steps;
    int         abort_k;
    logic [3:0] exp_out;
    int         exp_steps;
    int         exp_len;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rotf(input logic [3:0] v, input logic d);
    return d ? {v[0], v[3:1]} : {v[2:0], v[3]};
  endfunction

  task automatic issue(input logic [3:0] p, input logic d, input int n);
    cif.cmd_valid   = 1'b1;
    cif.cmd_pattern = p;
    cif.cmd_dir     = d;
    cif.cmd_steps   = 8'(n);
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [3:0] model;
    int nsteps;
    int done_c;
    bit busy_seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    model = v.pattern;
    nsteps = 0;
    done_c = -1;
    busy_seen = 0;
    chk({tag, "_ready"}, int'(cif.cmd_ready), 1);
    issue(v.pattern, v.dir, v.steps);
    for (int c = 0; c <= 200; c++) begin
      if (c > 0) begin
        abort = (v.abort_k != 0 && c == v.abort_k * 4);
        if (c == 2 && v.steps > 1) begin
          cif.cmd_valid   = 1'b1;
          cif.cmd_pattern = 4'b0101;
          cif.cmd_steps   = 8'd3;
        end
        @(posedge clk);
        #1;
        abort = 1'b0;
        cif.cmd_valid = 1'b0;
      end
      if (busy) busy_seen = 1;
      if (step) begin
        nsteps++;
        model = rotf(model, v.dir);
        chk({tag, "_stepval"}, int'(out), int'(model));
        chk({tag, "_steptime"}, c, nsteps * 4);
      end
      if (done) begin
        done_c = c;
        break;
      end
    end
    chk({tag, "_donetime"}, done_c, v.exp_len);
    chk({tag, "_out"}, int'(out), int'(v.exp_out));
    chk({tag, "_nsteps"}, nsteps, v.exp_steps);
    chk({tag, "_busy"}, int'(busy_seen), int'(v.steps != 0));
    @(posedge clk);
    #1;
    chk({tag, "_ready_after"}, int'(cif.cmd_ready), 1);
    chk({tag, "_done_1cyc"}, int'(done), 0);
  endtask

  initial begin
    int dp;
    vecs[0] = '{4'b0001, 1'b0, 5, 0, 4'b0010, 5, 20};
    vecs[1] = '{4'b1001, 1'b1, 2, 0, 4'b0110, 2, 8};
    vecs[2] = '{4'b1010, 1'b0, 0, 0, 4'b1010, 0, 0};
    vecs[3] = '{4'b0001, 1'b0, 8, 3, 4'b0100, 2, 12};
    vecs[4] = '{4'b1111, 1'b1, 3, 0, 4'b1111, 3, 12};
    vecs[5] = '{4'b0000, 1'b0, 1, 0, 4'b0000, 1, 4};
    vecs[6] = '{4'b0110, 1'b0, 2, 0, 4'b1001, 2, 8};

    reset = 1'b1;
    abort = 1'b0;
    cif.cmd_valid   = 1'b0;
    cif.cmd_pattern = 4'b0;
    cif.cmd_dir     = 1'b0;
    cif.cmd_steps   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", int'(out), 1);
    chk("rst_ready", int'(cif.cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // reset during RUN after the first rotation
    issue(4'b0001, 1'b0, 5);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_out_pre", int'(out), 4'b0010);
    chk("mid_busy_pre", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_out", int'(out), 1);
    chk("mid_ready", int'(cif.cmd_ready), 1);
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_step", int'(step), 0);
    dp = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done || step) dp++;
    end
    chk("mid_quiet", dp, 0);
    chk("mid_out_hold", int'(out), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
